dcache_wb_engine: RTL
=====================

Name: dcache_wb_engine

Overview:
- Writeback (victim eviction) engine for the custom CPU data cache.
- Reads one dirty line from the data array's asynchronous read port and latches it.
- Transmits the line to memory as one write burst: an address/length request handshake, then LINE_WORDS data beats with valid/ready.
- Counterpart to the refill path: refill writes the arrays from memory; this block reads the arrays out to memory.

Parameters:
- TAG_WIDTH, 24, tag bits of the line address
- IDX_WIDTH, 3, set index bits; also the array read address width
- WORD_WIDTH, 32, bits per memory data beat
- LINE_WORDS, 8, words per cache line; (32 - TAG_WIDTH - IDX_WIDTH) == log2(LINE_WORDS*WORD_WIDTH/8) is required

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_start  in  1  request to write back line at wb_index with wb_tag
- wb_tag  in  TAG_WIDTH  tag of the victim line
- wb_index  in  IDX_WIDTH  set index of the victim line
- wb_ready  out  1  engine idle, can accept wb_start
- wb_done  out  1  one-cycle pulse, burst fully accepted by memory
- arr_raddr  out  IDX_WIDTH  data array read address (combinational read)
- arr_rdata  in  LINE_WORDS*WORD_WIDTH  data array line; word 0 in the LSBs
- mem_wr_req_valid  out  1  write request valid
- mem_wr_req_ready  in  1  write request accepted
- mem_wr_addr  out  32  line base address {tag, index, zeros}
- mem_wr_len  out  8  beats minus one, constant LINE_WORDS-1
- mem_wr_data_valid  out  1  data beat valid
- mem_wr_data_ready  in  1  data beat accepted
- mem_wr_data  out  WORD_WIDTH  current beat
- mem_wr_data_last  out  1  final beat flag
- wb_count  out  32  completed writebacks (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, DATA, DONE. Register state, line buffer, address and beat counter. Drive all handshake outputs from registered state.
- Reset values: state=IDLE, wb_ready=1, wb_done=0, mem_wr_req_valid=0, mem_wr_data_valid=0, mem_wr_data_last=0, beat counter=0, wb_count=0. Line buffer, mem_wr_addr and mem_wr_data are don't-care but must not be X-propagating; clear them to 0.
- arr_raddr = wb_index, combinationally, at all times.
- IDLE: wb_ready=1. When wb_start=1:
  - latch arr_rdata into the line buffer;
  - latch the address {wb_tag, wb_index, 0s};
  - clear the beat counter;
  - go to REQ.
- wb_start outside IDLE is ignored.
- REQ: mem_wr_req_valid=1. mem_wr_addr and mem_wr_len are stable until the handshake. When valid&ready, go to DATA.
- DATA: mem_wr_data_valid=1 and mem_wr_data=buffer word[counter]. mem_wr_data_last=1 when counter==LINE_WORDS-1. Data is held stable while ready=0. On valid&ready:
  - if not last: counter+1;
  - if last: go to DONE.
- DONE: wb_done=1 for exactly one cycle, then IDLE.
- Timing: with start sampled at edge E0 and memory ready held high:
  - mem_wr_req_valid is high in cycle E0–E1;
  - beats occupy E1–E9;
  - wb_done is high in E9–E10;
  - wb_ready is high again from E10.
  - Minimum occupancy is LINE_WORDS+2 cycles.
- Back-to-back: wb_start in the first IDLE cycle after DONE is accepted.
- Reset mid-burst: the next edge returns the engine to IDLE. All valids drop and no wb_done pulse is produced. Reset wins over a simultaneous wb_start.
- The beat counter never wraps; its width is log2(LINE_WORDS).

Optional Feature:
- Macro DCACHE_WB_PERF_CNT_EN.
- Defined: wb_count increments by 1 on every DONE cycle and wraps modulo 2^32. It clears on rst.
- Undefined: wb_count is tied to 32'd0 and no counter register is synthesized.

Test Plan:
- Basic burst: after reset, wb_tag=24'hABCDEF, wb_index=3'd5, line words 0..7 = 32'h1000_0000+i, all readys high.
  - mem_wr_addr=32'hABCDEFA0, mem_wr_len=7.
  - Beats appear in order 1000_0000..1000_0007, with last only on the 8th beat.
  - wb_done is pulsed 10 cycles after start.
- Backpressure: mem_wr_req_ready low 4 cycles, then mem_wr_data_ready toggling 1/0.
  - Request fields and each beat are held stable while ready=0.
  - Exactly 8 beats are accepted and one wb_done pulse occurs.
- Busy ignore: assert wb_start with a different index during DATA.
  - The current burst is unaffected and wb_ready=0.
  - No second burst starts until wb_start is reasserted in IDLE.
- Array change after latch: alter arr_rdata during DATA.
  - Transmitted beats still equal the line captured at start.
- Reset mid-operation: assert rst at beat 3.
  - Next cycle: all valids=0, wb_ready=1, wb_done never pulses.
  - A new writeback then completes normally.
- Perf counter: three writebacks with DCACHE_WB_PERF_CNT_EN defined give wb_count=3.
  - With the macro undefined, wb_count stays 0.

Source files
------------

// File: rtl/dcache_wb_engine.sv
// Data-cache victim writeback engine: latches one dirty line and sends it to memory as a single write burst.
// Optional DCACHE_WB_PERF_CNT_EN adds a 32-bit count of completed writebacks on wb_count.
module dcache_wb_engine #(
  parameter int TAG_WIDTH  = 24,
  parameter int IDX_WIDTH  = 3,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_start,
  input  logic [TAG_WIDTH-1:0]             wb_tag,
  input  logic [IDX_WIDTH-1:0]             wb_index,
  output logic                             wb_ready,
  output logic                             wb_done,
  output logic [IDX_WIDTH-1:0]             arr_raddr,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] arr_rdata,
  output logic                             mem_wr_req_valid,
  input  logic                             mem_wr_req_ready,
  output logic [31:0]                      mem_wr_addr,
  output logic [7:0]                       mem_wr_len,
  output logic                             mem_wr_data_valid,
  input  logic                             mem_wr_data_ready,
  output logic [WORD_WIDTH-1:0]            mem_wr_data,
  output logic                             mem_wr_data_last,
  output logic [31:0]                      wb_count
);
  localparam int OFF_W = 32 - TAG_WIDTH - IDX_WIDTH;
  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                                state;
  logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]                      cnt;
  logic [CNT_W-1:0]                      cnt_nx;

  assign arr_raddr  = wb_index;
  assign mem_wr_len = 8'(LINE_WORDS - 1);
  assign cnt_nx     = cnt + CNT_W'(1);

  // The beat on the bus is preloaded one step ahead, so data and last come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      line_q            <= '0;
      cnt               <= '0;
      wb_ready          <= 1'b1;
      wb_done           <= 1'b0;
      mem_wr_req_valid  <= 1'b0;
      mem_wr_data_valid <= 1'b0;
      mem_wr_data_last  <= 1'b0;
      mem_wr_addr       <= '0;
      mem_wr_data       <= '0;
    end else begin
      case (state)
        IDLE: if (wb_start) begin
          line_q           <= arr_rdata;
          mem_wr_addr      <= {wb_tag, wb_index, {OFF_W{1'b0}}};
          cnt              <= '0;
          wb_ready         <= 1'b0;
          mem_wr_req_valid <= 1'b1;
          state            <= REQ;
        end
        REQ: if (mem_wr_req_ready) begin
          mem_wr_req_valid  <= 1'b0;
          mem_wr_data_valid <= 1'b1;
          mem_wr_data       <= line_q[0];
          mem_wr_data_last  <= (LAST_BEAT == '0);
          state             <= DATA;
        end
        DATA: if (mem_wr_data_ready) begin
          if (mem_wr_data_last) begin
            mem_wr_data_valid <= 1'b0;
            mem_wr_data_last  <= 1'b0;
            wb_done           <= 1'b1;
            state             <= DONE;
          end else begin
            cnt              <= cnt_nx;
            mem_wr_data      <= line_q[cnt_nx];
            mem_wr_data_last <= (cnt_nx == LAST_BEAT);
          end
        end
        DONE: begin
          wb_done  <= 1'b0;
          wb_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                wb_count <= '0;
    else if (state == DONE) wb_count <= wb_count + 32'd1;
  end
`else
  assign wb_count = 32'd0;
`endif

endmodule
